// File: rtl/hazard_forward_controller.sv
// -----------------------------------------------------------------------------
// hazard_forward_controller
//
// Sequencing controller for the ID/EX boundary of a 5-stage pipeline. Every
// cycle it:
//   * selects the ALU operand sources (register file, EX/MEM or MEM/WB),
//   * detects load-use and branch-operand hazards for the instruction in ID,
//     freezing PC and IF/ID and injecting a bubble while a hazard is pending,
//   * drives the PC-source selects for branch / jump / jr redirects and
//     flushes IF/ID when a redirect is taken.
// A small stall FSM stretches a branch-after-load hazard over
// LOAD_BRANCH_STALL cycles. Single-cycle hazards need no STALL state.
//
// Optional build macro: HAZARD_PERF_CNT_EN
//   defined   -> saturating stall / flush performance counters are built.
//   undefined -> stall_cycles_o and flush_count_o are tied to zero.
//
// Ports
//   clk_i                 clock, all state updates on the rising edge
//   reset_i               synchronous active-high reset
//   id_rs_i, id_rt_i      source registers of the ID instruction
//   id_uses_rt_i          ID instruction reads rt
//   id_branch_i           ID instruction is a conditional branch
//   id_jump_i, id_jr_i    ID instruction is j / jr
//   id_branch_equal_i     ID comparator result (rs == rt)
//   idex_rs_i, idex_rt_i  source registers of the EX instruction
//   idex_dest_i           destination of the EX instruction
//   idex_mem_read_i       EX instruction is a load
//   idex_reg_write_i      EX instruction writes the register file
//   exmem_dest_i          destination of the MEM instruction
//   exmem_mem_read_i      MEM instruction is a load
//   exmem_reg_write_i     MEM instruction writes the register file
//   memwb_dest_i          destination of the WB instruction
//   memwb_reg_write_i     WB instruction writes the register file
//   fwd_a_o, fwd_b_o      0 = regfile, 1 = EX/MEM forward, 2 = MEM/WB forward
//   stall_mux_sel_o       0 = bubble (zero control), 1 = pass control word
//   pc_write_o            PC write enable
//   ifid_write_o          IF/ID write enable
//   ifid_flush_o          zero the IF/ID instruction
//   pc_sel_branch_o       1st PC mux: take branch target
//   pc_sel_jump_o         2nd PC mux: take jump target
//   pc_sel_jr_o           3rd PC mux: take register target
//   stall_cycles_o        bubble cycles counted (perf counter)
//   flush_count_o         IF/ID flush cycles counted (perf counter)
// -----------------------------------------------------------------------------
module hazard_forward_controller #(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_BRANCH_STALL = 2,
  parameter int CNT_W             = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_uses_rt_i,
  input  logic                  id_branch_i,
  input  logic                  id_jump_i,
  input  logic                  id_jr_i,
  input  logic                  id_branch_equal_i,
  input  logic [REG_ADDR_W-1:0] idex_rs_i,
  input  logic [REG_ADDR_W-1:0] idex_rt_i,
  input  logic [REG_ADDR_W-1:0] idex_dest_i,
  input  logic                  idex_mem_read_i,
  input  logic                  idex_reg_write_i,
  input  logic [REG_ADDR_W-1:0] exmem_dest_i,
  input  logic                  exmem_mem_read_i,
  input  logic                  exmem_reg_write_i,
  input  logic [REG_ADDR_W-1:0] memwb_dest_i,
  input  logic                  memwb_reg_write_i,
  output logic [1:0]            fwd_a_o,
  output logic [1:0]            fwd_b_o,
  output logic                  stall_mux_sel_o,
  output logic                  pc_write_o,
  output logic                  ifid_write_o,
  output logic                  ifid_flush_o,
  output logic                  pc_sel_branch_o,
  output logic                  pc_sel_jump_o,
  output logic                  pc_sel_jr_o,
  output logic [CNT_W-1:0]      stall_cycles_o,
  output logic [CNT_W-1:0]      flush_count_o
);

  // Wide enough to hold LOAD_BRANCH_STALL - 1, never narrower than one bit.
  localparam int CNT_BITS = (LOAD_BRANCH_STALL > 1) ? $clog2(LOAD_BRANCH_STALL + 1) : 1;
  localparam logic [CNT_BITS-1:0] BR2_LOAD = CNT_BITS'(LOAD_BRANCH_STALL - 1);
  localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  logic [1:0] fwd_a_s, fwd_b_s;
  logic       dep_ex_s, dep_mem_s, ctl_s;
  logic       lu_s, br1_s, br2_s, hazard_s;
  logic       stall_mux_sel_s, pc_write_s, ifid_write_s, ifid_flush_s;
  logic       pc_sel_branch_s, pc_sel_jump_s, pc_sel_jr_s;

  // Forward select for one operand: the younger producer (EX/MEM) wins and
  // register 0 is hard-wired, so it never forwards. Code 3 is unreachable.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] src,
    input logic                  exmem_we,
    input logic [REG_ADDR_W-1:0] exmem_dst,
    input logic                  memwb_we,
    input logic [REG_ADDR_W-1:0] memwb_dst
  );
    logic [1:0] sel;
    if (exmem_we && (exmem_dst != {REG_ADDR_W{1'b0}}) && (exmem_dst == src)) begin
      sel = 2'd1;
    end else if (memwb_we && (memwb_dst != {REG_ADDR_W{1'b0}}) && (memwb_dst == src)) begin
      sel = 2'd2;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  // True when the ID instruction reads register x (and x is not r0).
  function automatic logic dep_match(
    input logic [REG_ADDR_W-1:0] x,
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rt,
    input logic                  uses_rt
  );
    return (x != {REG_ADDR_W{1'b0}}) && ((x == rs) || (uses_rt && (x == rt)));
  endfunction

  // Operand forwarding selects, independent of the stall FSM.
  always_comb begin
    fwd_a_s = fwd_sel(idex_rs_i, exmem_reg_write_i, exmem_dest_i, memwb_reg_write_i, memwb_dest_i);
    fwd_b_s = fwd_sel(idex_rt_i, exmem_reg_write_i, exmem_dest_i, memwb_reg_write_i, memwb_dest_i);
  end

  // Hazard classification of the ID instruction against EX and MEM.
  always_comb begin
    dep_ex_s  = dep_match(idex_dest_i, id_rs_i, id_rt_i, id_uses_rt_i);
    dep_mem_s = dep_match(exmem_dest_i, id_rs_i, id_rt_i, id_uses_rt_i);
    ctl_s     = id_branch_i | id_jr_i;
    lu_s      = idex_mem_read_i & dep_ex_s;
    // Branch operands are compared in ID, so an ALU result still in EX or a
    // load still in MEM is not yet available to the comparator.
    br1_s     = ctl_s & ((idex_reg_write_i & ~idex_mem_read_i & dep_ex_s) |
                         (exmem_mem_read_i & dep_mem_s));
    br2_s     = ctl_s & idex_mem_read_i & dep_ex_s;
    hazard_s  = lu_s | br1_s | br2_s;
  end

  // Stall FSM next-state and pipeline control outputs.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    stall_mux_sel_s = 1'b0;
    pc_write_s      = 1'b0;
    ifid_write_s    = 1'b0;
    ifid_flush_s    = 1'b0;
    pc_sel_branch_s = 1'b0;
    pc_sel_jump_s   = 1'b0;
    pc_sel_jr_s     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (hazard_s) begin
          // Hazard cycle is itself the first bubble; only BR2 needs more.
          cnt_d = br2_s ? BR2_LOAD : CNT_ZERO;
          if (cnt_d != CNT_ZERO) begin
            state_d = ST_STALL;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          stall_mux_sel_s = 1'b1;
          pc_write_s      = 1'b1;
          ifid_write_s    = 1'b1;
          pc_sel_branch_s = id_branch_i & id_branch_equal_i;
          pc_sel_jump_s   = id_jump_i;
          pc_sel_jr_s     = id_jr_i;
          ifid_flush_s    = (id_branch_i & id_branch_equal_i) | id_jump_i | id_jr_i;
          state_d         = ST_RUN;
        end
      end
      ST_STALL: begin
        // No hazard re-evaluation here; the count alone decides the exit.
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_STALL;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Stall FSM state and countdown registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_RUN;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output stage: reset forces a safe frozen-and-flushed pipeline.
  always_comb begin
    if (reset_i) begin
      fwd_a_o         = 2'd0;
      fwd_b_o         = 2'd0;
      stall_mux_sel_o = 1'b0;
      pc_write_o      = 1'b0;
      ifid_write_o    = 1'b0;
      ifid_flush_o    = 1'b1;
      pc_sel_branch_o = 1'b0;
      pc_sel_jump_o   = 1'b0;
      pc_sel_jr_o     = 1'b0;
    end else begin
      fwd_a_o         = fwd_a_s;
      fwd_b_o         = fwd_b_s;
      stall_mux_sel_o = stall_mux_sel_s;
      pc_write_o      = pc_write_s;
      ifid_write_o    = ifid_write_s;
      ifid_flush_o    = ifid_flush_s;
      pc_sel_branch_o = pc_sel_branch_s;
      pc_sel_jump_o   = pc_sel_jump_s;
      pc_sel_jr_o     = pc_sel_jr_s;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q;
  logic [CNT_W-1:0] flush_count_q;

  // Saturating counters of bubble cycles and IF/ID flush cycles.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_cycles_q <= {CNT_W{1'b0}};
      flush_count_q  <= {CNT_W{1'b0}};
    end else begin
      if (!stall_mux_sel_s && (stall_cycles_q != {CNT_W{1'b1}})) begin
        stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      end else begin
        stall_cycles_q <= stall_cycles_q;
      end
      if (ifid_flush_s && (flush_count_q != {CNT_W{1'b1}})) begin
        flush_count_q <= flush_count_q + CNT_W'(1);
      end else begin
        flush_count_q <= flush_count_q;
      end
    end
  end

  assign stall_cycles_o = reset_i ? {CNT_W{1'b0}} : stall_cycles_q;
  assign flush_count_o  = reset_i ? {CNT_W{1'b0}} : flush_count_q;
`else
  assign stall_cycles_o = {CNT_W{1'b0}};
  assign flush_count_o  = {CNT_W{1'b0}};
`endif

endmodule
